// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg
//   Shared definitions for the Gray-to-binary converter arbiter:
//   Gray word width, output-stage state encoding and a reference
//   gray2bin function (MSB first: b3=g3, bk=b(k+1)^gk).
package gray_conv_pkg;

  localparam int GW = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin
//   Combinational Gray-to-binary converter.
//   Ports:
//     gray  in  GW   Gray-coded word
//     bin   out GW   binary equivalent
module gray_to_bin
  import gray_conv_pkg::*;
(
  input  logic [GW-1:0] gray,
  output logic [GW-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it; written as
  // a reduction so there is no bit-to-bit combinational chain.
  generate
    for (genvar gi = 0; gi < GW; gi++) begin : g_bit
      assign bin[gi] = ^gray[GW-1:gi];
    end
  endgenerate

endmodule

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches req starting just after
//   'last' (last+1, last+2, ... mod N) and returns the first set index.
//   Ports:
//     req   in  N     request vector
//     last  in  IDW   index granted most recently
//     any   out 1     at least one request present
//     idx   out IDW   winning index (0 when any=0)
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic           any,
  output logic [IDW-1:0] idx
);

  // Walk from the farthest offset to the nearest so the closest requester
  // after 'last' overwrites the others and ends up as the winner.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int o = N; o >= 1; o--) begin
      int k;
      k = (int'(last) + o) % N;
      if (req[k]) begin
        any = 1'b1;
        idx = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Shares one Gray-to-binary converter among N requesters using a
//   round-robin arbiter and a single-entry tagged output stage.
//   Ports:
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     req_valid  in   N      requester k offers req_gray[4k+3:4k]
//     req_gray   in   4*N    packed Gray words
//     req_ready  out  N      one-hot (or zero) accept strobe
//     out_valid  out  1      output stage holds a converted word
//     out_bin    out  4      converted binary value
//     out_id     out  IDW    requester index of out_bin
//     out_ready  in   1      consumer takes the output word this cycle
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [GW*N-1:0] req_gray,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [GW-1:0]   out_bin,
  output logic [IDW-1:0]  out_id,
  input  logic            out_ready
);

  state_t         state_reg, state_next;
  logic [IDW-1:0] rr_last_reg, rr_last_next;
  logic [GW-1:0]  out_bin_reg, out_bin_next;
  logic [IDW-1:0] out_id_reg, out_id_next;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic [GW-1:0]  win_gray;
  logic [GW-1:0]  win_bin;
  logic           can_load;
  logic           fire;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req  (req_valid),
    .last (rr_last_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign win_gray = req_gray[int'(pick_idx)*GW +: GW];

  gray_to_bin u_g2b (
    .gray (win_gray),
    .bin  (win_bin)
  );

  // out_valid is exactly the FULL state, so draining only needs out_ready.
  assign out_valid = (state_reg == ST_FULL);
  assign can_load  = (state_reg == ST_EMPTY) | out_ready;
  // Gate with rst_n so no requester sees an accept while reset is held.
  assign fire      = pick_any & can_load & rst_n;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign req_ready[gi] = fire & (pick_idx == IDW'(gi));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    rr_last_next = rr_last_reg;
    out_bin_next = out_bin_reg;
    out_id_next  = out_id_reg;
    if (fire) begin
      state_next   = ST_FULL;
      rr_last_next = pick_idx;
      out_bin_next = win_bin;
      out_id_next  = pick_idx;
    end else if (state_reg == ST_FULL && out_ready) begin
      // Drained with nothing to refill: data/tag keep their last values.
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_EMPTY;
      rr_last_reg <= IDW'(N - 1);
      out_bin_reg <= '0;
      out_id_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      rr_last_reg <= rr_last_next;
      out_bin_reg <= out_bin_next;
      out_id_reg  <= out_id_next;
    end
  end

  assign out_bin = out_bin_reg;
  assign out_id  = out_id_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
module tb_gray_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_gray;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_bin;
  logic [1:0]  out_id;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  gray_conv_arbiter #(.N(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_gray  (req_gray),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out_chk(input string tag, input logic v, input logic [3:0] b, input logic [1:0] id);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".bin"},   {28'd0, out_bin},   {28'd0, b});
    chk({tag, ".id"},    {30'd0, out_id},    {30'd0, id});
    $display("[%0t] %s: valid=%0b bin=%b id=%0d ready=%b", $time, tag, out_valid, out_bin, out_id, req_ready);
  endtask

  // Hand-computed Gray->binary values for the burst test.
  logic [3:0] exp_bin [4];
  logic [3:0] exp_rdy [4];

  initial begin
    exp_bin[0] = 4'b0000;  // gray 0000
    exp_bin[1] = 4'b0001;  // gray 0001
    exp_bin[2] = 4'b1111;  // gray 1000
    exp_bin[3] = 4'b1000;  // gray 1100
    exp_rdy[0] = 4'b0001;
    exp_rdy[1] = 4'b0010;
    exp_rdy[2] = 4'b0100;
    exp_rdy[3] = 4'b1000;

    // 1: reset with random inputs
    rst_n     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'($urandom);
      req_gray  = 16'($urandom);
      out_ready = 1'($urandom);
      #1;
      chk("rst.req_ready", {28'd0, req_ready}, 32'd0);
      out_chk("rst", 1'b0, 4'b0000, 2'd0);
      step();
    end
    req_valid = 4'b0000;
    req_gray  = 16'h0000;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("idle.req_ready", {28'd0, req_ready}, 32'd0);
    step();
    out_chk("idle", 1'b0, 4'b0000, 2'd0);

    // 2: single requester 0, gray 1011 -> 1101
    req_valid = 4'b0001;
    req_gray  = 16'h000B;
    #1;
    chk("single.req_ready", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0000;
    #1;
    out_chk("single", 1'b1, 4'b1101, 2'd0);

    // Drain and reset so requester 0 leads the burst.
    out_ready = 1'b1;
    step();
    out_chk("drain", 1'b0, 4'b1101, 2'd0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    // 3: all four requesting, out_ready=1
    req_gray  = 16'hC810;  // k3=1100 k2=1000 k1=0001 k0=0000
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("burst.first_ready", {28'd0, req_ready}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      out_chk($sformatf("burst%0d", i), 1'b1, exp_bin[i%4], 2'(i % 4));
      chk($sformatf("burst%0d.req_ready", i), {28'd0, req_ready}, {28'd0, exp_rdy[(i+1)%4]});
    end

    // 4: stall with requests pending; word id1 bin 0001 held
    out_ready = 1'b0;
    #1;
    chk("stall.req_ready", {28'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      out_chk($sformatf("stall%0d", i), 1'b1, 4'b0001, 2'd1);
      chk($sformatf("stall%0d.req_ready", i), {28'd0, req_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall.req_ready", {28'd0, req_ready}, 32'h4);
    step();
    out_chk("unstall", 1'b1, 4'b1111, 2'd2);

    // 5: rotation checks (rr_last=2)
    req_valid = 4'b0010;
    #1;
    chk("rot.k1_ready", {28'd0, req_ready}, 32'h2);
    step();
    out_chk("rot.k1", 1'b1, 4'b0001, 2'd1);
    req_valid = 4'b1000;
    #1;
    chk("rot.k3_ready", {28'd0, req_ready}, 32'h8);
    step();
    out_chk("rot.k3", 1'b1, 4'b1000, 2'd3);
    req_gray[3:0] = 4'b0110;  // -> 0100
    req_valid     = 4'b0101;
    #1;
    chk("rot.k0k2_ready", {28'd0, req_ready}, 32'h1);
    step();
    out_chk("rot.k0", 1'b1, 4'b0100, 2'd0);
    req_valid = 4'b0000;
    step();
    out_chk("empty_keep", 1'b0, 4'b0100, 2'd0);
    step();
    req_valid = 4'b1111;
    #1;
    chk("no_idle_rotate.ready", {28'd0, req_ready}, 32'h2);

    // 6: async reset while FULL with a pending request
    step();
    out_chk("pre_rst", 1'b1, 4'b0001, 2'd1);
    out_ready     = 1'b0;
    req_gray[3:0] = 4'b1011;
    req_valid     = 4'b0001;
    #1;
    chk("pre_rst.req_ready", {28'd0, req_ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    out_chk("async_rst", 1'b0, 4'b0000, 2'd0);
    chk("async_rst.req_ready", {28'd0, req_ready}, 32'd0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'b0011;
    #1;
    chk("post_rst.req_ready", {28'd0, req_ready}, 32'h1);
    step();
    out_chk("post_rst", 1'b1, 4'b1101, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
